// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes, master FSM states
// and the command bundle used by the master and its benches.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int CMD_ADDR_W = 4;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } mst_state_e;

    typedef struct packed {
        logic                      write;
        logic [CMD_ADDR_W-1:0]     addr;
        logic [CMD_DATA_W-1:0]     wdata;
        logic [CMD_DATA_W/8-1:0]   wstrb;
    } cmd_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command in, one AXI read or write out,
// one response back. A single transaction in flight at a time.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH_p = 4,
    parameter int DATA_WIDTH_p = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDR_WIDTH_p-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH_p-1:0]   i_cmd_wdata,
    input  logic [DATA_WIDTH_p/8-1:0] i_cmd_wstrb,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic                      o_rsp_write,
    output logic [DATA_WIDTH_p-1:0]   o_rsp_rdata,
    output logic [1:0]                o_rsp_resp,
    output logic [ADDR_WIDTH_p-1:0]   o_axi_awaddr,
    output logic                      o_axi_awvalid,
    input  logic                      i_axi_awready,
    output logic [DATA_WIDTH_p-1:0]   o_axi_wdata,
    output logic [DATA_WIDTH_p/8-1:0] o_axi_wstrb,
    output logic                      o_axi_wvalid,
    input  logic                      i_axi_wready,
    input  logic [1:0]                i_axi_bresp,
    input  logic                      i_axi_bvalid,
    output logic                      o_axi_bready,
    output logic [ADDR_WIDTH_p-1:0]   o_axi_araddr,
    output logic                      o_axi_arvalid,
    input  logic                      i_axi_arready,
    input  logic [DATA_WIDTH_p-1:0]   i_axi_rdata,
    input  logic [1:0]                i_axi_rresp,
    input  logic                      i_axi_rvalid,
    output logic                      o_axi_rready
);

    localparam int STRB_W = DATA_WIDTH_p / 8;
    localparam logic [ADDR_WIDTH_p-1:0] ALIGN_MASK = ~ADDR_WIDTH_p'(3);

    if (DATA_WIDTH_p != 32) begin : g_bad_width
        $error("axi_lite_master supports DATA_WIDTH_p == 32 only");
    end

    mst_state_e                state_q, state_d;
    logic [ADDR_WIDTH_p-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH_p-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic                      write_q, write_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      bready_q, bready_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH_p-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      aw_hs, w_hs;

    assign aw_hs = awvalid_q && i_axi_awready;
    assign w_hs  = wvalid_q && i_axi_wready;

    // Next state and next value of every registered output.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr & ALIGN_MASK;
                    wdata_d = i_cmd_wdata;
                    wstrb_d = i_cmd_wstrb;
                    write_d = i_cmd_write;
                    if (i_cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently, possibly together.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (i_axi_bvalid) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = i_axi_bresp;
                end
            end
            RD_REQ: begin
                if (i_axi_arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (i_axi_rvalid) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = i_axi_rdata;
                    rsp_resp_d  = i_axi_rresp;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_axi_awaddr  = addr_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_bready  = bready_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_rready  = rready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_write   = rsp_write_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small scratchpad
// responder with programmable per-channel wait states.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [3:0]  i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_write;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic [3:0]  o_axi_awaddr, o_axi_araddr;
    logic        o_axi_awvalid, i_axi_awready;
    logic [31:0] o_axi_wdata, i_axi_rdata;
    logic [3:0]  o_axi_wstrb;
    logic        o_axi_wvalid, i_axi_wready;
    logic [1:0]  i_axi_bresp, i_axi_rresp;
    logic        i_axi_bvalid, o_axi_bready;
    logic        o_axi_arvalid, i_axi_arready;
    logic        i_axi_rvalid, o_axi_rready;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_WIDTH_p(4), .DATA_WIDTH_p(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr),
        .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_write(o_rsp_write), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid),
        .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
        .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid),
        .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid),
        .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
        .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready)
    );

    // Responder model: scratchpad of 4 words with wait-state knobs.
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  b_resp_cfg, r_resp_cfg;
    int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [3:0]  aw_a, ar_a, w_s, wr_a, wr_s;
    logic [31:0] w_d, wr_d;
    logic [31:0] mem [4];
    logic        aw_hs, w_hs, ar_hs;
    int          rsp_cnt;

    assign i_axi_awready = o_axi_awvalid && !aw_got && (aw_wait >= aw_dly);
    assign i_axi_wready  = o_axi_wvalid && !w_got && (w_wait >= w_dly);
    assign i_axi_bvalid  = b_pend && (b_cnt >= b_dly);
    assign i_axi_bresp   = i_axi_bvalid ? b_resp_cfg : 2'b00;
    assign i_axi_arready = o_axi_arvalid && !r_pend && (ar_wait >= ar_dly);
    assign i_axi_rvalid  = r_pend && (r_cnt >= r_dly);
    assign i_axi_rdata   = i_axi_rvalid ? mem[ar_a[3:2]] : 32'h0;
    assign i_axi_rresp   = i_axi_rvalid ? r_resp_cfg : 2'b00;
    assign aw_hs = o_axi_awvalid && i_axi_awready;
    assign w_hs  = o_axi_wvalid && i_axi_wready;
    assign ar_hs = o_axi_arvalid && i_axi_arready;
    assign wr_a  = aw_hs ? o_axi_awaddr : aw_a;
    assign wr_d  = w_hs ? o_axi_wdata : w_d;
    assign wr_s  = w_hs ? o_axi_wstrb : w_s;

    // Responder state; reset together with the master.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            b_pend <= 1'b0; r_pend <= 1'b0;
            aw_a <= '0; ar_a <= '0; w_s <= '0; w_d <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            aw_wait <= (o_axi_awvalid && !aw_hs) ? aw_wait + 1 : 0;
            w_wait  <= (o_axi_wvalid && !w_hs) ? w_wait + 1 : 0;
            ar_wait <= (o_axi_arvalid && !ar_hs) ? ar_wait + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; aw_a <= o_axi_awaddr; end
            if (w_hs) begin
                w_got <= 1'b1; w_d <= o_axi_wdata; w_s <= o_axi_wstrb;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                b_pend <= 1'b1; b_cnt <= 0;
                for (int i = 0; i < 4; i++)
                    if (wr_s[i]) mem[wr_a[3:2]][8*i +: 8] <= wr_d[8*i +: 8];
            end
            if (b_pend) begin
                if (i_axi_bvalid && o_axi_bready) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end
            if (ar_hs) begin r_pend <= 1'b1; r_cnt <= 0; ar_a <= o_axi_araddr; end
            if (r_pend) begin
                if (i_axi_rvalid && o_axi_rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    // Count completed response handshakes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_cnt <= 0;
        else if (o_rsp_valid && i_rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input cmd_t c);
        i_cmd_valid = 1'b1;
        i_cmd_write = c.write;
        i_cmd_addr  = c.addr;
        i_cmd_wdata = c.wdata;
        i_cmd_wstrb = c.wstrb;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!o_rsp_valid && n < 40) begin
            tick();
            n++;
        end
        if (!o_rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_rsp();
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0;
        i_cmd_wdata = 0; i_cmd_wstrb = 0; i_rsp_ready = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_awvalid", o_axi_awvalid, 0);
        chk("rst_wvalid", o_axi_wvalid, 0);
        chk("rst_arvalid", o_axi_arvalid, 0);
        chk("rst_bready", o_axi_bready, 0);
        chk("rst_rready", o_axi_rready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_rdata", o_rsp_rdata, 0);
        chk("rst_rsp_resp", o_rsp_resp, 0);
        chk("rst_awaddr", o_axi_awaddr, 0);
        #2 rst_n = 1'b1;
        tick();

        // zero-wait write of 0xDEADBEEF to 0x4
        issue('{write: 1'b1, addr: 4'h4, wdata: 32'hDEADBEEF, wstrb: 4'hF});
        chk("w1_awvalid", o_axi_awvalid, 1);
        chk("w1_wvalid", o_axi_wvalid, 1);
        chk("w1_awaddr", o_axi_awaddr, 4'h4);
        chk("w1_wdata", o_axi_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", o_axi_wstrb, 4'hF);
        chk("w1_cmd_ready", o_cmd_ready, 0);
        tick();
        chk("w1_bready", o_axi_bready, 1);
        chk("w1_aw_drop", o_axi_awvalid, 0);
        chk("w1_w_drop", o_axi_wvalid, 0);
        tick();
        chk("w1_rsp_valid", o_rsp_valid, 1);
        chk("w1_rsp_write", o_rsp_write, 1);
        chk("w1_rsp_rdata", o_rsp_rdata, 0);
        chk("w1_rsp_resp", o_rsp_resp, RESP_OKAY);
        chk("w1_bready_low", o_axi_bready, 0);
        take_rsp();
        chk("w1_idle_ready", o_cmd_ready, 1);
        chk("w1_rsp_clear", o_rsp_valid, 0);

        // zero-wait read back of 0x4
        issue('{write: 1'b0, addr: 4'h4, wdata: 32'h0, wstrb: 4'h0});
        chk("r1_arvalid", o_axi_arvalid, 1);
        chk("r1_araddr", o_axi_araddr, 4'h4);
        tick();
        chk("r1_rready", o_axi_rready, 1);
        chk("r1_ar_drop", o_axi_arvalid, 0);
        tick();
        chk("r1_rsp_valid", o_rsp_valid, 1);
        chk("r1_rdata", o_rsp_rdata, 32'hDEADBEEF);
        chk("r1_rsp_write", o_rsp_write, 0);
        chk("r1_rready_low", o_axi_rready, 0);
        take_rsp();

        // W accepted three cycles after AW
        w_dly = 3;
        issue('{write: 1'b1, addr: 4'h8, wdata: 32'h12345678, wstrb: 4'hF});
        chk("w2_awvalid", o_axi_awvalid, 1);
        chk("w2_wvalid", o_axi_wvalid, 1);
        tick();
        chk("w2_aw_drop", o_axi_awvalid, 0);
        chk("w2_w_hold1", o_axi_wvalid, 1);
        tick();
        chk("w2_w_hold2", o_axi_wvalid, 1);
        chk("w2_wdata", o_axi_wdata, 32'h12345678);
        chk("w2_no_bready", o_axi_bready, 0);
        tick();
        chk("w2_w_hold3", o_axi_wvalid, 1);
        chk("w2_no_bready2", o_axi_bready, 0);
        tick();
        chk("w2_w_drop", o_axi_wvalid, 0);
        chk("w2_bready", o_axi_bready, 1);
        tick();
        chk("w2_rsp_valid", o_rsp_valid, 1);
        n0 = rsp_cnt;
        take_rsp();
        repeat (3) tick();
        chk("w2_single_rsp", rsp_cnt, n0 + 1);
        chk("w2_rsp_clear", o_rsp_valid, 0);
        w_dly = 0;

        // read of 0x8 with R delayed five cycles
        r_dly = 5;
        issue('{write: 1'b0, addr: 4'h8, wdata: 32'h0, wstrb: 4'h0});
        chk("r2_arvalid", o_axi_arvalid, 1);
        tick();
        chk("r2_ar_drop", o_axi_arvalid, 0);
        for (int i = 0; i < 5; i++) begin
            chk("r2_rready_hold", o_axi_rready, 1);
            chk("r2_no_rsp", o_rsp_valid, 0);
            tick();
        end
        chk("r2_rready_at_r", o_axi_rready, 1);
        tick();
        chk("r2_rsp_valid", o_rsp_valid, 1);
        chk("r2_rdata", o_rsp_rdata, 32'h12345678);
        chk("r2_rready_low", o_axi_rready, 0);
        take_rsp();
        r_dly = 0;

        // unaligned address and partial strobes
        issue('{write: 1'b1, addr: 4'h7, wdata: 32'hA5A5A5A5, wstrb: 4'h3});
        chk("w3_awaddr_align", o_axi_awaddr, 4'h4);
        wait_rsp();
        take_rsp();
        issue('{write: 1'b0, addr: 4'h6, wdata: 32'h0, wstrb: 4'h0});
        chk("r3_araddr_align", o_axi_araddr, 4'h4);
        wait_rsp();
        chk("r3_rdata_strb", o_rsp_rdata, 32'hDEADA5A5);
        take_rsp();

        // SLVERR write with response back-pressure
        b_resp_cfg = RESP_SLVERR;
        issue('{write: 1'b1, addr: 4'h0, wdata: 32'h1, wstrb: 4'hF});
        wait_rsp();
        for (int i = 0; i < 4; i++) begin
            chk("w4_rsp_hold", o_rsp_valid, 1);
            chk("w4_resp", o_rsp_resp, RESP_SLVERR);
            chk("w4_write", o_rsp_write, 1);
            chk("w4_cmd_ready", o_cmd_ready, 0);
            tick();
        end
        take_rsp();
        b_resp_cfg = RESP_OKAY;

        // DECERR read passes through
        r_resp_cfg = RESP_DECERR;
        issue('{write: 1'b0, addr: 4'h0, wdata: 32'h0, wstrb: 4'h0});
        wait_rsp();
        chk("r4_resp", o_rsp_resp, RESP_DECERR);
        chk("r4_rdata", o_rsp_rdata, 32'h1);
        take_rsp();
        r_resp_cfg = RESP_OKAY;

        // reset while stuck in WR_REQ
        aw_dly = 10; w_dly = 10;
        issue('{write: 1'b1, addr: 4'hC, wdata: 32'h55, wstrb: 4'hF});
        chk("w5_awvalid", o_axi_awvalid, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("w5_rst_aw", o_axi_awvalid, 0);
        chk("w5_rst_w", o_axi_wvalid, 0);
        chk("w5_rst_cmd_ready", o_cmd_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        aw_dly = 0; w_dly = 0;
        tick();
        chk("w5_post_ready", o_cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("w5_no_rsp", o_rsp_valid, 0);
            chk("w5_no_aw", o_axi_awvalid, 0);
            tick();
        end
        issue('{write: 1'b0, addr: 4'h4, wdata: 32'h0, wstrb: 4'h0});
        wait_rsp();
        chk("w5_read_after_rst", o_rsp_rdata, 32'h0);
        take_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator that turns a simple single-command request/response interface into AXI4-Lite read or write transactions.
- Sits in front of AXI4-Lite responders such as the team's scratchpad and drives their AW/W/B/AR/R channels.
- It is also the stimulus engine for integration benches against the scratchpad.
- Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH_p, 4, byte-address width of the AXI and command address buses (16-byte space = 4 words of 32 bits).
- DATA_WIDTH_p, 32, data width; only 32 is supported. Any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_cmd_valid  input  1  command request.
- o_cmd_ready  output  1  command accepted when i_cmd_valid && o_cmd_ready.
- i_cmd_write  input  1  1 = write, 0 = read.
- i_cmd_addr  input  ADDR_WIDTH_p  byte address.
- i_cmd_wdata  input  32  write data.
- i_cmd_wstrb  input  4  write byte strobes.
- o_rsp_valid  output  1  response available.
- i_rsp_ready  input  1  response consumed.
- o_rsp_write  output  1  response belongs to a write.
- o_rsp_rdata  output  32  read data; 0 for writes.
- o_rsp_resp  output  2  AXI BRESP/RRESP as captured.
- o_axi_awaddr  output  ADDR_WIDTH_p
- o_axi_awvalid  output  1
- i_axi_awready  input  1
- o_axi_wdata  output  32
- o_axi_wstrb  output  4
- o_axi_wvalid  output  1
- i_axi_wready  input  1
- i_axi_bresp  input  2
- i_axi_bvalid  input  1
- o_axi_bready  output  1
- o_axi_araddr  output  ADDR_WIDTH_p
- o_axi_arvalid  output  1
- i_axi_arready  input  1
- i_axi_rdata  input  32
- i_axi_rresp  input  2
- i_axi_rvalid  input  1
- o_axi_rready  output  1

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All valid and ready outputs are 0, except o_cmd_ready, which is 1 (combinational from IDLE).
  - Address, data, strobe, rdata and resp registers are 0.
- Reset mid-transaction abandons the transaction with no response; the responder is reset alongside.
- Outputs: all AXI outputs and o_rsp_* are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - o_cmd_ready = 1.
  - On accept, latch the address with bits [1:0] forced to 0, plus wdata, wstrb and the write flag.
  - Write → WR_REQ with awvalid = wvalid = 1 in the next cycle.
  - Read → RD_REQ with arvalid = 1 in the next cycle.
- WR_REQ:
  - AW and W are independent. Each valid drops the cycle after its own handshake.
  - awaddr, wdata and wstrb stay stable while their valid is high.
  - Done flags track each handshake, including same-cycle AW and W acceptance.
  - When both handshakes are complete → WR_RESP with bready = 1.
- WR_RESP:
  - On bvalid, capture bresp, set rdata = 0 and rsp_write = 1, drop bready, go to RSP.
  - bready is never high outside WR_RESP.
- RD_REQ: on arready, drop arvalid, raise rready, go to RD_RESP.
- RD_RESP: on rvalid, capture rdata and rresp, set rsp_write = 0, drop rready, go to RSP.
- RSP:
  - o_rsp_valid = 1, with o_rsp_* stable until i_rsp_ready.
  - On i_rsp_ready → IDLE.
  - The next command can be accepted the cycle after the response handshake.
- Valids never drop without a handshake. Response codes, including SLVERR/DECERR, are passed through unmodified; there is no retry.
- Zero-wait responder latency:
  - Write: accept at cycle T, AW/W at T+1, bready at T+2, rsp_valid at T+3 at the earliest.
  - Read: accept at T, AR at T+1, R at T+2, rsp_valid at T+3.
- Late bvalid/rvalid: bready/rready are held indefinitely; there is no timeout.

Decomposition:
- axi_lite_pkg holds:
  - Response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - The master state enum (typedef).
  - A cmd struct of write, addr, wdata and wstrb, shared with the scratchpad benches.
- No sub-module: the FSM plus capture registers form one module.

Test Plan:
- Write 0xDEADBEEF, wstrb 0xF, addr 0x4 to a zero-wait scratchpad → AW/W at T+1, rsp_valid at T+3 with resp 00, rsp_write = 1, rdata = 0. A subsequent read of 0x4 returns 0xDEADBEEF.
- Write with wready delayed 3 cycles after awready → awvalid drops after its handshake while wvalid/wdata stay stable. bready rises only after the W handshake. A single response is produced.
- Read of 0x8 with rvalid delayed 5 cycles → rready held high throughout; rdata captured on the rvalid cycle; arvalid low after the handshake.
- Command addr 0x7 → awaddr driven as 0x4.
- Responder returns bresp 2'b10 → o_rsp_resp = 2'b10. i_rsp_ready held low for 4 cycles keeps the response stable and o_cmd_ready = 0.
- rst_n asserted while in WR_REQ → awvalid/wvalid low immediately, state IDLE, o_cmd_ready = 1 after release, no o_rsp_valid.
